// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters (CPU port A, loader/debug port B),
// the arbiter and the single-ported-write data RAM.
interface ram_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic        a_lock;
  logic [4:0]  a_addr;
  logic [18:0] a_wdata;
  logic        a_gnt;
  logic        a_rvalid;
  logic [18:0] a_rdata;
  logic        a_stall;

  logic        b_req;
  logic        b_we;
  logic        b_lock;
  logic [4:0]  b_addr;
  logic [18:0] b_wdata;
  logic        b_gnt;
  logic        b_rvalid;
  logic [18:0] b_rdata;
  logic        b_stall;

  logic        ram_we;
  logic [4:0]  ram_waddr;
  logic [18:0] ram_wdata;
  logic [4:0]  ram_raddr;
  logic [18:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata, a_stall,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata, b_stall,
    output ram_we, ram_waddr, ram_wdata, ram_raddr,
    input  ram_rdata
  );

  // Requester / RAM side
  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata, a_stall,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata, b_stall,
    input  ram_we, ram_waddr, ram_wdata, ram_raddr,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter: one owner at a time, ties go to the port that did not
// own last, locked bursts are bounded by MAX_BURST when the other port waits.
module ram_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t        state_q, state_d;
  state_t        other_s;
  logic          last_b_q, last_b_d;
  logic [CW-1:0] burst_q, burst_d, burst_inc_s;
  logic          own_req_s, own_lock_s, oth_req_s;
  logic          txn_a_s, txn_b_s;
  logic          a_rvalid_q, b_rvalid_q;
  logic [18:0]   a_rdata_q, b_rdata_q;

  assign txn_a_s     = (state_q == OWN_A) && bus.a_req;
  assign txn_b_s     = (state_q == OWN_B) && bus.b_req;
  assign burst_inc_s = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 1'b1;

  assign bus.a_gnt    = (state_q == OWN_A);
  assign bus.b_gnt    = (state_q == OWN_B);
  assign bus.a_stall  = bus.a_req && (state_q != OWN_A);
  assign bus.b_stall  = bus.b_req && (state_q != OWN_B);
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;

  // Owner-relative view of the requester signals
  always_comb begin
    own_req_s  = 1'b0;
    own_lock_s = 1'b0;
    oth_req_s  = 1'b0;
    other_s    = IDLE;
    if (state_q == OWN_A) begin
      own_req_s  = bus.a_req;
      own_lock_s = bus.a_lock;
      oth_req_s  = bus.b_req;
      other_s    = OWN_B;
    end else if (state_q == OWN_B) begin
      own_req_s  = bus.b_req;
      own_lock_s = bus.b_lock;
      oth_req_s  = bus.a_req;
      other_s    = OWN_A;
    end else begin
      other_s    = IDLE;
    end
  end

  // Next-state, burst count and last-owner tracking
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    burst_d  = burst_q;
    case (state_q)
      IDLE: begin
        burst_d = {CW{1'b0}};
        if (bus.a_req && bus.b_req) begin
          state_d = last_b_q ? OWN_A : OWN_B;
        end else if (bus.a_req) begin
          state_d = OWN_A;
        end else if (bus.b_req) begin
          state_d = OWN_B;
        end else begin
          state_d = IDLE;
        end
      end
      OWN_A, OWN_B: begin
        // Any exit from ownership restarts the burst and records who left
        if (!own_req_s || (oth_req_s && (!own_lock_s || burst_inc_s >= BURST_MAX))) begin
          state_d  = oth_req_s ? other_s : IDLE;
          burst_d  = {CW{1'b0}};
          last_b_d = (state_q == OWN_B);
        end else begin
          burst_d  = burst_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = {CW{1'b0}};
      end
    endcase
  end

  // RAM port mux: only the transacting owner reaches the RAM
  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_waddr = 5'd0;
    bus.ram_raddr = 5'd0;
    bus.ram_wdata = 19'd0;
    if (txn_a_s) begin
      bus.ram_we    = bus.a_we;
      bus.ram_waddr = bus.a_addr;
      bus.ram_raddr = bus.a_addr;
      bus.ram_wdata = bus.a_wdata;
    end else if (txn_b_s) begin
      bus.ram_we    = bus.b_we;
      bus.ram_waddr = bus.b_addr;
      bus.ram_raddr = bus.b_addr;
      bus.ram_wdata = bus.b_wdata;
    end else begin
      bus.ram_we    = 1'b0;
    end
  end

  // Arbitration state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      burst_q  <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      burst_q  <= burst_d;
    end
  end

  // Read capture: rdata holds until the next read on the same port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= 19'd0;
      b_rdata_q  <= 19'd0;
    end else begin
      a_rvalid_q <= txn_a_s && !bus.a_we;
      b_rvalid_q <= txn_b_s && !bus.b_we;
      if (txn_a_s && !bus.a_we) begin
        a_rdata_q <= bus.ram_rdata;
      end
      if (txn_b_s && !bus.b_we) begin
        b_rdata_q <= bus.ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scenario bench for ram_arbiter; read results go through per-port queues.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [18:0] pl_data;
  logic [18:0] mem [32];
  logic [18:0] qa [$];
  logic [18:0] qb [$];
  int          errors;
  int          checks;

  ram_arbiter_if bus ();

  ram_arbiter #(.MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data RAM with a preload path
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
  end
  assign bus.ram_rdata = mem[bus.ram_raddr];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_lock = 1'b0; bus.a_addr = 5'd0; bus.a_wdata = 19'd0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_lock = 1'b0; bus.b_addr = 5'd0; bus.b_wdata = 19'd0;
  endtask

  task automatic preload(input logic [4:0] a, input logic [18:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    next_cycle();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pl_en = 1'b0; pl_addr = 5'd0; pl_data = 19'd0;
    drive_idle();
    #1;
    checks++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.ram_we} !== 5'b00000) begin
      errors++;
      $display("FAIL rst_ctrl: got %b expected 00000", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.ram_we});
    end
    checks++;
    if (bus.a_rdata !== 19'd0 || bus.b_rdata !== 19'd0) begin
      errors++;
      $display("FAIL rst_rdata: got %h/%h expected 0/0", bus.a_rdata, bus.b_rdata);
    end
    preload(5'd5, 19'h01234);
    preload(5'd3, 19'h00ABC);
    preload(5'd7, 19'h5A5A5);
    preload(5'd2, 19'h33333);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_gnt: got %b%b expected 00", bus.a_gnt, bus.b_gnt);
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    logic [18:0] exp;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 5'd5;
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b0 || bus.a_stall !== 1'b1) begin
      errors++;
      $display("FAIL rd_c0: got gnt=%b stall=%b expected gnt=0 stall=1", bus.a_gnt, bus.a_stall);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b1 || bus.a_stall !== 1'b0) begin
      errors++;
      $display("FAIL rd_c1_gnt: got gnt=%b stall=%b expected gnt=1 stall=0", bus.a_gnt, bus.a_stall);
    end
    checks++;
    if (bus.ram_raddr !== 5'd5 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rd_c1_raddr: got %0d we=%b expected 5 we=0", bus.ram_raddr, bus.ram_we);
    end
    qa.push_back(19'h01234);
    next_cycle();
    bus.a_req = 1'b0;
    @(negedge clk);
    exp = qa.pop_front();
    checks++;
    if (bus.a_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rd_c2_rvalid: got %b expected 1", bus.a_rvalid);
    end
    checks++;
    if (bus.a_rdata !== exp) begin
      errors++;
      $display("FAIL rd_c2_rdata: got %h expected %h", bus.a_rdata, exp);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.a_rvalid !== 1'b0 || bus.a_gnt !== 1'b0 || bus.a_rdata !== 19'h01234) begin
      errors++;
      $display("FAIL rd_c3_hold: got rv=%b gnt=%b rdata=%h expected 0 0 01234", bus.a_rvalid, bus.a_gnt, bus.a_rdata);
    end
    next_cycle();
  endtask

  task automatic test_write();
    logic [18:0] exp;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 5'd31; bus.b_wdata = 19'h7FFFF;
    bus.a_req = 1'b0; bus.a_we = 1'b1; bus.a_addr = 5'd9; bus.a_wdata = 19'h11111;
    @(negedge clk);
    checks++;
    if (bus.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL wr_c0_we: got %b expected 0", bus.ram_we);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.b_gnt, bus.ram_we, bus.ram_waddr, bus.ram_wdata} !== {1'b1, 1'b1, 5'd31, 19'h7FFFF}) begin
      errors++;
      $display("FAIL wr_c1_bus: got gnt=%b we=%b a=%0d d=%h expected 1 1 31 7ffff",
               bus.b_gnt, bus.ram_we, bus.ram_waddr, bus.ram_wdata);
    end
    next_cycle();
    bus.b_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ram_we !== 1'b0 || bus.b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_c2_done: got we=%b rv=%b expected 0 0", bus.ram_we, bus.b_rvalid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.b_rvalid !== 1'b0 || bus.b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL wr_c3_idle: got rv=%b gnt=%b expected 0 0", bus.b_rvalid, bus.b_gnt);
    end
    next_cycle();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 5'd31;
    qa.push_back(19'h7FFFF);
    next_cycle();
    next_cycle();
    bus.a_req = 1'b0;
    @(negedge clk);
    exp = qa.pop_front();
    checks++;
    if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== exp) begin
      errors++;
      $display("FAIL wr_readback: got rv=%b rdata=%h expected 1 %h", bus.a_rvalid, bus.a_rdata, exp);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_burst();
    logic [18:0] exp;
    int nwr;
    int last_wr;
    int got_at;
    nwr = 0; last_wr = -10; got_at = -1;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_lock = 1'b1;
    for (int k = 0; k < 24 && got_at < 0; k++) begin
      if (k == 1) begin
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 5'd2; bus.a_lock = 1'b0;
      end
      bus.b_addr = 5'(16 + k);
      bus.b_wdata = 19'(100 + k);
      @(negedge clk);
      if (bus.b_gnt && bus.ram_we) begin
        nwr++;
        last_wr = k;
        checks++;
        if (bus.ram_waddr !== bus.b_addr || bus.ram_wdata !== bus.b_wdata) begin
          errors++;
          $display("FAIL burst_wr_bus: got %0d/%h expected %0d/%h", bus.ram_waddr, bus.ram_wdata, bus.b_addr, bus.b_wdata);
        end
      end
      if (bus.a_gnt) begin
        got_at = k;
      end else begin
        next_cycle();
      end
    end
    checks++;
    if (got_at < 0) begin
      errors++;
      $display("FAIL burst_handover: got no a_gnt within 24 cycles expected a_gnt");
    end
    checks++;
    if (nwr !== 8) begin
      errors++;
      $display("FAIL burst_count: got %0d writes expected 8", nwr);
    end
    checks++;
    if (got_at !== last_wr + 1) begin
      errors++;
      $display("FAIL burst_gap: got a_gnt at %0d expected %0d", got_at, last_wr + 1);
    end
    checks++;
    if (bus.ram_we !== 1'b0 || bus.ram_raddr !== 5'd2) begin
      errors++;
      $display("FAIL burst_a_txn: got we=%b raddr=%0d expected 0 2", bus.ram_we, bus.ram_raddr);
    end
    qa.push_back(19'h33333);
    next_cycle();
    drive_idle();
    @(negedge clk);
    exp = qa.pop_front();
    checks++;
    if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== exp) begin
      errors++;
      $display("FAIL burst_a_read: got rv=%b rdata=%h expected 1 %h", bus.a_rvalid, bus.a_rdata, exp);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_stall();
    logic [18:0] exp;
    int stalls;
    int got_at;
    stalls = 0; got_at = -1;
    bus.a_req = 1'b1; bus.a_lock = 1'b1; bus.a_we = 1'b1; bus.a_addr = 5'd20; bus.a_wdata = 19'h0F0F0;
    for (int k = 0; k < 24 && got_at < 0; k++) begin
      if (k == 1) begin
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 5'd31; bus.b_lock = 1'b0;
      end
      @(negedge clk);
      if (bus.b_gnt) begin
        got_at = k;
      end else begin
        if (k >= 1) begin
          stalls++;
          checks++;
          if (bus.b_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_b: got %b expected 1 at cycle %0d", bus.b_stall, k);
          end
          checks++;
          if (bus.a_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_a: got %b expected 0 at cycle %0d", bus.a_stall, k);
          end
        end
        next_cycle();
      end
    end
    checks++;
    if (got_at !== 9) begin
      errors++;
      $display("FAIL stall_gnt_cycle: got %0d expected 9", got_at);
    end
    checks++;
    if (stalls !== 8) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected 8", stalls);
    end
    checks++;
    if (bus.a_gnt !== 1'b0 || bus.b_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_switch: got a_gnt=%b b_stall=%b expected 0 0", bus.a_gnt, bus.b_stall);
    end
    qb.push_back(19'h7FFFF);
    next_cycle();
    drive_idle();
    @(negedge clk);
    exp = qb.pop_front();
    checks++;
    if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== exp) begin
      errors++;
      $display("FAIL stall_b_read: got rv=%b rdata=%h expected 1 %h", bus.b_rvalid, bus.b_rdata, exp);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 5'd5;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rmr_gnt: got %b expected 1", bus.a_gnt);
    end
    qa.push_back(19'h01234);
    next_cycle();
    reset = 1'b0;
    qa.delete();
    bus.a_req = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 5'd7; bus.b_wdata = 19'h00001;
    #1;
    checks++;
    if ({bus.a_rvalid, bus.a_gnt, bus.ram_we} !== 3'b000 || bus.a_rdata !== 19'd0) begin
      errors++;
      $display("FAIL rmr_immediate: got rv=%b gnt=%b we=%b rdata=%h expected 0 0 0 0",
               bus.a_rvalid, bus.a_gnt, bus.ram_we, bus.a_rdata);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.ram_we !== 1'b0 || bus.b_gnt !== 1'b0 || bus.a_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rmr_hold: got we=%b b_gnt=%b rv=%b expected 0 0 0", bus.ram_we, bus.b_gnt, bus.a_rvalid);
      end
    end
    next_cycle();
    drive_idle();
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_tie();
    logic [18:0] exp;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 5'd3;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 5'd7;
    @(negedge clk);
    checks++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_stall, bus.b_stall} !== 4'b0011) begin
      errors++;
      $display("FAIL tie_c0: got %b expected 0011", {bus.a_gnt, bus.b_gnt, bus.a_stall, bus.b_stall});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.a_gnt, bus.b_gnt, bus.b_stall} !== 3'b101 || bus.ram_raddr !== 5'd3) begin
      errors++;
      $display("FAIL tie_c1_a_first: got gnt=%b%b stall_b=%b raddr=%0d expected 10 1 3",
               bus.a_gnt, bus.b_gnt, bus.b_stall, bus.ram_raddr);
    end
    qa.push_back(19'h00ABC);
    next_cycle();
    bus.a_req = 1'b0;
    @(negedge clk);
    exp = qa.pop_front();
    checks++;
    if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0 || bus.ram_raddr !== 5'd7) begin
      errors++;
      $display("FAIL tie_c2_handover: got gnt=%b%b raddr=%0d expected 01 7", bus.a_gnt, bus.b_gnt, bus.ram_raddr);
    end
    checks++;
    if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== exp) begin
      errors++;
      $display("FAIL tie_c2_a_read: got rv=%b rdata=%h expected 1 %h", bus.a_rvalid, bus.a_rdata, exp);
    end
    qb.push_back(19'h5A5A5);
    next_cycle();
    bus.b_req = 1'b0;
    @(negedge clk);
    exp = qb.pop_front();
    checks++;
    if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== exp) begin
      errors++;
      $display("FAIL tie_c3_b_read: got rv=%b rdata=%h expected 1 %h", bus.b_rvalid, bus.b_rdata, exp);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_c4_idle: got %b%b expected 00", bus.a_gnt, bus.b_gnt);
    end
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 5'd10; bus.a_wdata = 19'h2AAAA;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 5'd11; bus.b_wdata = 19'h15555;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.a_gnt, bus.b_gnt, bus.ram_we, bus.ram_waddr, bus.ram_wdata} !== {2'b10, 1'b1, 5'd10, 19'h2AAAA}) begin
      errors++;
      $display("FAIL tie_c5_again_a: got gnt=%b%b we=%b a=%0d d=%h expected 10 1 10 2aaaa",
               bus.a_gnt, bus.b_gnt, bus.ram_we, bus.ram_waddr, bus.ram_wdata);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.b_gnt !== 1'b1 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL tie_c6_no_req: got b_gnt=%b we=%b expected 1 0", bus.b_gnt, bus.ram_we);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_c7_idle: got %b%b expected 00", bus.a_gnt, bus.b_gnt);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_read();
    test_write();
    test_burst();
    test_stall();
    test_reset_mid_read();
    test_tie();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
